// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential sign-magnitude divider.
interface seq_divider_if #(parameter int MAG_W = 2);
  logic               start;
  logic [MAG_W:0]     a;
  logic [MAG_W:0]     b;
  logic               busy;
  logic               done;
  logic [MAG_W+2:0]   quo;
  logic [MAG_W+2:0]   rem;
  logic               divbyzeroflag;

  modport master (output start, a, b, input busy, done, quo, rem, divbyzeroflag);
  modport slave  (input start, a, b, output busy, done, quo, rem, divbyzeroflag);
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider for sign-magnitude operands, one quotient bit per cycle.
// Result encodings match the combinational remainder unit (sign in MSB, magnitude in low bits).
module seq_divider #(
  parameter int MAG_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;
  logic [MAG_W-1:0]   b_mag_q, b_mag_d;
  logic [MAG_W:0]     r_q, r_d;
  logic [MAG_W-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [MAG_W+2:0]   quo_q, quo_d;
  logic [MAG_W+2:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [MAG_W:0]     r_sh, r_nx;
  logic [MAG_W-1:0]   q_nx;
  logic               ge;

  always_comb begin
    r_sh = {r_q[MAG_W-1:0], q_q[MAG_W-1]};
    ge   = (r_sh >= {1'b0, b_mag_q});
    r_nx = ge ? (r_sh - {1'b0, b_mag_q}) : r_sh;
    q_nx = {q_q[MAG_W-2:0], ge};
  end

  always_comb begin
    state_d  = state_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    b_mag_d  = b_mag_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sign_d = bus.a[MAG_W];
          b_sign_d = bus.b[MAG_W];
          b_mag_d  = bus.b[MAG_W-1:0];
          r_d      = '0;
          q_d      = bus.a[MAG_W-1:0];
          cnt_d    = CNT_W'(MAG_W);
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (b_mag_q == '0) begin
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = r_nx;
          q_d   = q_nx;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Zero magnitudes force a positive sign so -0 never leaves the block.
            quo_d                = '0;
            quo_d[MAG_W-1:0]     = q_nx;
            quo_d[MAG_W+2]       = (a_sign_q ^ b_sign_q) & (q_nx != '0);
            rem_d                = '0;
            rem_d[MAG_W-1:0]     = r_nx[MAG_W-1:0];
            rem_d[MAG_W+2]       = a_sign_q & (r_nx != '0);
            dbz_d                = 1'b0;
            done_d               = 1'b1;
            state_d              = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      b_mag_q  <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      b_mag_q  <= b_mag_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.quo           = quo_q;
  assign bus.rem           = rem_q;
  assign bus.divbyzeroflag = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, sign rules, divide-by-zero, robustness, full operand sweep.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.MAG_W(2)) dif ();

  seq_divider #(.MAG_W(2)) dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;

  // One division; start sampled at the first posedge, operands scrambled afterwards.
  task automatic do_div(input logic [2:0] av, input logic [2:0] bv,
                        output logic [4:0] q, output logic [4:0] r, output logic z,
                        output int lat, output bit to, output logic busy0,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    dif.a = av; dif.b = bv; dif.start = 1'b1;
    @(posedge clk); #1;
    busy0 = dif.busy;
    dif.start = 1'b0; dif.a = ~av; dif.b = ~bv;
    lat = 0; to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dif.done) begin to = 1'b0; break; end
    end
    q = dif.quo; r = dif.rem; z = dif.divbyzeroflag;
    @(posedge clk); #1;
    done_after = dif.done; busy_after = dif.busy;
  endtask

  task automatic test_reset;
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dif.busy, dif.done, dif.quo, dif.rem, dif.divbyzeroflag} !== 13'b0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b quo=%b rem=%b dbz=%b want all 0",
               dif.busy, dif.done, dif.quo, dif.rem, dif.divbyzeroflag);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [2:0] ta [5] = '{3'b011, 3'b111, 3'b110, 3'b010, 3'b001};
    logic [2:0] tb [5] = '{3'b010, 3'b010, 3'b101, 3'b011, 3'b011};
    logic [4:0] eq [5] = '{5'b00001, 5'b10001, 5'b00010, 5'b00000, 5'b00000};
    logic [4:0] er [5] = '{5'b00001, 5'b10001, 5'b00000, 5'b00010, 5'b00001};
    logic [4:0] q, r; logic z, b0, da, ba; int lat; bit to;
    for (int k = 0; k < 5; k++) begin
      do_div(ta[k], tb[k], q, r, z, lat, to, b0, da, ba);
      total++;
      if (to || lat != 2) begin
        bad++; $display("FAIL basic_latency[%0d] got lat=%0d timeout=%0b want 2", k, lat, to);
      end
      total++;
      if (q !== eq[k] || r !== er[k] || z !== 1'b0) begin
        bad++; $display("FAIL basic_result[%0d] got quo=%b rem=%b dbz=%b want quo=%b rem=%b dbz=0",
                        k, q, r, z, eq[k], er[k]);
      end
      total++;
      if (b0 !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin
        bad++; $display("FAIL basic_handshake[%0d] got busy0=%b done_after=%b busy_after=%b want 1 0 0",
                        k, b0, da, ba);
      end
    end
  endtask

  task automatic test_divzero;
    logic [2:0] tb [2] = '{3'b000, 3'b100};
    logic [4:0] q, r; logic z, b0, da, ba; int lat; bit to;
    for (int k = 0; k < 2; k++) begin
      do_div(3'b001, tb[k], q, r, z, lat, to, b0, da, ba);
      total++;
      if (to || lat != 1) begin
        bad++; $display("FAIL dbz_latency[%0d] got lat=%0d timeout=%0b want 1", k, lat, to);
      end
      total++;
      if (q !== 5'b0 || r !== 5'b0 || z !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin
        bad++; $display("FAIL dbz_result[%0d] got quo=%b rem=%b dbz=%b done_after=%b busy_after=%b want 0 0 1 0 0",
                        k, q, r, z, da, ba);
      end
    end
    do_div(3'b011, 3'b001, q, r, z, lat, to, b0, da, ba);
    total++;
    if (to || q !== 5'b00011 || r !== 5'b0 || z !== 1'b0) begin
      bad++; $display("FAIL dbz_clear got quo=%b rem=%b dbz=%b timeout=%0b want 00011 00000 0", q, r, z, to);
    end
  endtask

  task automatic test_negzero;
    logic [2:0] tb [2] = '{3'b110, 3'b010};
    logic [4:0] q, r; logic z, b0, da, ba; int lat; bit to;
    for (int k = 0; k < 2; k++) begin
      do_div(3'b100, tb[k], q, r, z, lat, to, b0, da, ba);
      total++;
      if (to || q !== 5'b0 || r !== 5'b0 || z !== 1'b0) begin
        bad++; $display("FAIL negzero[%0d] got quo=%b rem=%b dbz=%b want 00000 00000 0", k, q, r, z);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] q1, r1, q2, r2; logic z1, z2, b0, da, ba; int lat1, lat2; bit to1, to2;
    do_div(3'b011, 3'b011, q1, r1, z1, lat1, to1, b0, da, ba);
    do_div(3'b111, 3'b001, q2, r2, z2, lat2, to2, b0, da, ba);
    total++;
    if (to1 || to2 || q1 !== 5'b00001 || r1 !== 5'b0 || q2 !== 5'b10011 || r2 !== 5'b0) begin
      bad++; $display("FAIL back_to_back got q1=%b r1=%b q2=%b r2=%b want 00001 00000 10011 00000", q1, r1, q2, r2);
    end
  endtask

  task automatic test_start_held;
    int dones = 0;
    @(negedge clk);
    dif.a = 3'b011; dif.b = 3'b001; dif.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dif.done) dones++;
    end
    dif.start = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (dif.done) dones++; end
    total++;
    if (dones != 3 || dif.quo !== 5'b00011 || dif.busy !== 1'b0) begin
      bad++; $display("FAIL start_held got dones=%0d quo=%b busy=%b want 3 00011 0", dones, dif.quo, dif.busy);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    logic [4:0] q, r; logic z, b0, da, ba; int lat; bit to;
    @(negedge clk);
    dif.a = 3'b010; dif.b = 3'b011; dif.start = 1'b1;
    @(posedge clk); #1; dif.start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if ({dif.busy, dif.done, dif.quo, dif.rem, dif.divbyzeroflag} !== 13'b0) begin
      bad++; $display("FAIL reset_mid_outputs got busy=%b done=%b quo=%b rem=%b dbz=%b want all 0",
                      dif.busy, dif.done, dif.quo, dif.rem, dif.divbyzeroflag);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (dif.done || dif.busy) dones++; end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL reset_mid_no_done got active_cycles=%0d want 0", dones);
    end
    do_div(3'b011, 3'b010, q, r, z, lat, to, b0, da, ba);
    total++;
    if (to || lat != 2 || q !== 5'b00001 || r !== 5'b00001) begin
      bad++; $display("FAIL reset_mid_fresh got lat=%0d quo=%b rem=%b want 2 00001 00001", lat, q, r);
    end
  endtask

  task automatic test_sweep;
    logic [4:0] q, r, eq, er; logic z, ez, b0, da, ba; int lat, am, bm; bit to;
    int errs = 0;
    for (int i = 0; i < 64; i++) begin
      logic [2:0] av, bv;
      av = i[5:3]; bv = i[2:0];
      am = int'(av[1:0]); bm = int'(bv[1:0]);
      eq = '0; er = '0; ez = (bm == 0);
      if (!ez) begin
        eq[1:0] = 2'(am / bm);
        er[1:0] = 2'(am % bm);
        eq[4] = (av[2] ^ bv[2]) && (am / bm != 0);
        er[4] = av[2] && (am % bm != 0);
      end
      do_div(av, bv, q, r, z, lat, to, b0, da, ba);
      if (to || q !== eq || r !== er || z !== ez || lat != (ez ? 1 : 2)) begin
        errs++;
        $display("FAIL sweep a=%b b=%b got quo=%b rem=%b dbz=%b lat=%0d want %b %b %b %0d",
                 av, bv, q, r, z, lat, eq, er, ez, ez ? 1 : 2);
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL sweep_total got %0d wrong pairs want 0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divzero();
    test_negzero();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
